// File: rtl/dg0045_pkg.sv
// Shared definitions for the DG0045 program-fetch responder.
// Contents: FSM state type, program-store geometry, NOP opcode and the helper
// that rebuilds the 10-bit fetch address from the two multiplexed PC halves.
package dg0045_pkg;

  typedef enum logic [1:0] {
    StLoPh,
    StHiPh,
    StRead,
    StLoad
  } state_e;

  localparam int unsigned ROM_DEPTH  = 1024;
  localparam logic [7:0]  NOP_OPCODE = 8'h00;

  // pc_hl carries PL[4:0] in the low phase and {PU[3:0], PL[5]} in the high phase.
  localparam int unsigned PC_HL_W = 5;

  // {PU[3:0], PL[5], PL[4:0]}: raw bits, no polynomial-counter translation.
  function automatic logic [2*PC_HL_W-1:0] pc_join(input logic [PC_HL_W-1:0] hi,
                                                   input logic [PC_HL_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dg0045_rom_1kx8.sv
// Single-port synchronous-read RAM holding the DG0045 program store.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (clears the read register only)
//   re    - read enable; rdata updates only on a read
//   we    - write enable
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data
module dg0045_rom_1kx8
  import dg0045_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register holds between reads, so writes never disturb rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= DATA_W'(NOP_OPCODE);
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dg0045_rom_responder.sv
// Memory-side partner of the DG0045 CPU program-fetch interface.
// Alternates pc_mux low/high for PHASE_CYCLES each, samples both PC halves,
// reads the program store in a one-cycle READ state and presents the byte on
// rom_data. A host can program the store through the load port when idle.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   pc_hl        - multiplexed PC halves from the CPU
//   pc_mux       - half select to the CPU (0: PL[4:0], 1: {PU, PL5})
//   rom_data     - instruction byte to the CPU
//   rom_valid    - one-cycle pulse when rom_data changes value
//   fetch_addr   - last assembled fetch address
//   load_en      - host requests program-load mode
//   load_valid   - host write beat valid
//   load_addr    - host write address
//   load_data    - host write data
//   load_ready   - beat accepted this cycle
//   busy         - high outside the load state
module dg0045_rom_responder
  import dg0045_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_HL_W-1:0] pc_hl,
  output logic               pc_mux,
  output logic [DATA_W-1:0]  rom_data,
  output logic               rom_valid,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
  output logic               load_ready,
  output logic               busy
);

  localparam logic [3:0] CntLast = 4'(PHASE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_HL_W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]   last_q;

  logic                ram_re, ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    fetch_addr_d = fetch_addr_q;
    rd_pend_d    = 1'b0;
    ram_re       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = ADDR_W'(pc_join(hi_q, lo_q));
    pc_mux       = 1'b0;
    load_ready   = 1'b0;
    busy         = 1'b1;

    unique case (state_q)
      StLoPh: begin
        // Load entry only at the start of a loop, right after rom_data settled.
        if (cnt_q == 4'd0 && load_en) begin
          state_d = StLoad;
        end else if (cnt_q == CntLast) begin
          lo_d    = pc_hl;
          cnt_d   = 4'd0;
          state_d = StHiPh;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHiPh: begin
        pc_mux = 1'b1;
        if (cnt_q == CntLast) begin
          hi_d    = pc_hl;
          cnt_d   = 4'd0;
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRead: begin
        ram_re       = 1'b1;
        fetch_addr_d = ADDR_W'(pc_join(hi_q, lo_q));
        rd_pend_d    = 1'b1;
        state_d      = StLoPh;
      end
      StLoad: begin
        busy       = 1'b0;
        load_ready = 1'b1;
        ram_addr   = load_addr;
        // A beat coinciding with reset is dropped.
        ram_we     = load_valid & ~rst;
        if (!load_en) begin
          cnt_d   = 4'd0;
          state_d = StLoPh;
        end
      end
      default: state_d = StLoPh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoPh;
      cnt_q        <= 4'd0;
      lo_q         <= '0;
      hi_q         <= '0;
      fetch_addr_q <= '0;
      rd_pend_q    <= 1'b0;
      last_q       <= DATA_W'(NOP_OPCODE);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      fetch_addr_q <= fetch_addr_d;
      rd_pend_q    <= rd_pend_d;
      last_q       <= ram_rdata;
    end
  end

  dg0045_rom_1kx8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // rom_data is the RAM read register itself; last_q lags it by one cycle,
  // so the compare sees old vs new in the cycle after READ.
  assign rom_data   = ram_rdata;
  assign rom_valid  = rd_pend_q & (ram_rdata != last_q);
  assign fetch_addr = fetch_addr_q;

endmodule

// File: tb/tb_dg0045_rom_responder.sv
// Self-checking bench for dg0045_rom_responder: a CPU model answers pc_mux,
// a monitor pushes the expected fetch result when the high phase ends and
// checks it on the following cycle; directed steps cover load and reset.
module tb_dg0045_rom_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [7:0] rom_data;
  logic       rom_valid;
  logic [9:0] fetch_addr;
  logic       load_en, load_valid;
  logic [9:0] load_addr;
  logic [7:0] load_data;
  logic       load_ready, busy;

  logic [4:0] cpu_lo, cpu_hi;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_model [1024];

  always #5 clk = ~clk;

  // CPU side: present the half the responder selects.
  assign pc_hl = pc_mux ? cpu_hi : cpu_lo;

  dg0045_rom_responder #(
    .PHASE_CYCLES (4),
    .ADDR_W       (10),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_hl      (pc_hl),
    .pc_mux     (pc_mux),
    .rom_data   (rom_data),
    .rom_valid  (rom_valid),
    .fetch_addr (fetch_addr),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: tracks the values the responder samples at each phase end.
  initial begin : monitor
    logic       prev_mux;
    logic [4:0] lo_cand, hi_cand, lo_used;
    logic [7:0] model_last;
    exp_t       e;
    prev_mux   = 1'b0;
    lo_cand    = '0;
    hi_cand    = '0;
    lo_used    = '0;
    model_last = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_mux   = 1'b0;
        model_last = 8'h00;
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("mon_fetch_addr", 32'(fetch_addr), 32'(e.addr));
          check_eq("mon_rom_data", 32'(rom_data), 32'(e.data));
          check_eq("mon_rom_valid", 32'(rom_valid), 32'(e.valid));
        end else begin
          check_eq("mon_no_stray_valid", 32'(rom_valid), 0);
        end
        if (!prev_mux && pc_mux) lo_used = lo_cand;
        if (prev_mux && !pc_mux) begin
          e.addr     = {hi_cand, lo_used};
          e.data     = mem_model[e.addr];
          e.valid    = (e.data != model_last);
          model_last = e.data;
          exp_q.push_back(e);
        end
        if (pc_mux) hi_cand = pc_hl;
        else        lo_cand = pc_hl;
        prev_mux = pc_mux;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read();
    logic p;
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      p = pc_mux;
      tick();
      if (p && !pc_mux) found = 1'b1;
    end
    check_eq("read_reached", 32'(found), 1);
  endtask

  task automatic wait_fetch();
    wait_read();
    tick();
  endtask

  task automatic wait_hi();
    for (int n = 0; n < 60 && !pc_mux; n++) tick();
    check_eq("hi_reached", 32'(pc_mux), 1);
  endtask

  task automatic enter_load();
    load_en = 1'b1;
    for (int n = 0; n < 40 && !load_ready; n++) tick();
    check_eq("load_entered", 32'(load_ready), 1);
  endtask

  task automatic write_beat(input logic [9:0] a, input logic [7:0] d, input bit last,
                            input int gap);
    check_eq("load_pc_mux", 32'(pc_mux), 0);
    check_eq("load_ready", 32'(load_ready), 1);
    check_eq("load_busy", 32'(busy), 0);
    load_valid   = 1'b1;
    load_addr    = a;
    load_data    = d;
    mem_model[a] = d;
    if (last) load_en = 1'b0;
    tick();
    load_valid = 1'b0;
    load_addr  = 10'h000;
    load_data  = 8'hFF;
    for (int g = 0; g < gap; g++) begin
      check_eq("gap_ready", 32'(load_ready), 1);
      check_eq("gap_pc_mux", 32'(pc_mux), 0);
      tick();
    end
    if (last) begin
      check_eq("exit_busy", 32'(busy), 1);
      check_eq("exit_ready", 32'(load_ready), 0);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    rst        = 1'b1;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    cpu_lo     = '0;
    cpu_hi     = '0;
    repeat (3) tick();

    check_eq("rst_pc_mux", 32'(pc_mux), 0);
    check_eq("rst_rom_data", 32'(rom_data), 0);
    check_eq("rst_rom_valid", 32'(rom_valid), 0);
    check_eq("rst_fetch_addr", 32'(fetch_addr), 0);
    check_eq("rst_load_ready", 32'(load_ready), 0);
    check_eq("rst_busy", 32'(busy), 1);

    // Preload mem[0]=NOP, then idle at PC 0: 9-cycle loop, no valid pulses.
    rst = 1'b0;
    enter_load();
    write_beat(10'h000, 8'h00, 1'b1, 0);
    wait_read();
    for (int k = 1; k <= 18; k++) begin
      tick();
      check_eq("loop_pc_mux", 32'(pc_mux), 32'((k % 9) >= 5));
      check_eq("idle_rom_data", 32'(rom_data), 0);
    end

    // Program 3C5=C7 and fetch it.
    enter_load();
    cpu_lo = 5'h05;
    cpu_hi = 5'h1E;
    write_beat(10'h3C5, 8'hC7, 1'b1, 0);
    wait_fetch();
    check_eq("f1_addr", 32'(fetch_addr), 'h3C5);
    check_eq("f1_data", 32'(rom_data), 'hC7);
    check_eq("f1_valid", 32'(rom_valid), 1);
    tick();
    check_eq("f1_valid_one_cycle", 32'(rom_valid), 0);

    // Same address again: data steady for two loops.
    for (int k = 0; k < 18; k++) begin
      check_eq("hold_rom_data", 32'(rom_data), 'hC7);
      tick();
    end

    // load_en raised in the high phase: fetch completes first.
    wait_hi();
    load_en = 1'b1;
    wait_read();
    check_eq("midhi_ready_read", 32'(load_ready), 0);
    tick();
    check_eq("midhi_ready_out", 32'(load_ready), 0);
    check_eq("midhi_addr", 32'(fetch_addr), 'h3C5);
    check_eq("midhi_data", 32'(rom_data), 'hC7);
    tick();
    check_eq("midhi_in_load", 32'(load_ready), 1);
    cpu_lo = 5'h00;
    cpu_hi = 5'h00;
    write_beat(10'h000, 8'h40, 1'b0, 1);
    write_beat(10'h001, 8'h18, 1'b0, 2);
    write_beat(10'h002, 8'h5E, 1'b1, 0);

    wait_fetch();
    check_eq("rb0_addr", 32'(fetch_addr), 0);
    check_eq("rb0_data", 32'(rom_data), 'h40);
    check_eq("rb0_valid", 32'(rom_valid), 1);
    cpu_lo = 5'h01;
    wait_fetch();
    check_eq("rb1_data", 32'(rom_data), 'h18);
    cpu_lo = 5'h02;
    wait_fetch();
    check_eq("rb2_data", 32'(rom_data), 'h5E);

    // Reset in the high phase after lo was sampled; next fetch uses fresh samples.
    cpu_lo = 5'h11;
    cpu_hi = 5'h03;
    wait_hi();
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    cpu_lo = 5'h05;
    cpu_hi = 5'h1E;
    check_eq("mrst_pc_mux", 32'(pc_mux), 0);
    check_eq("mrst_rom_data", 32'(rom_data), 0);
    check_eq("mrst_fetch_addr", 32'(fetch_addr), 0);
    check_eq("mrst_rom_valid", 32'(rom_valid), 0);
    wait_fetch();
    check_eq("post_rst_addr", 32'(fetch_addr), 'h3C5);
    check_eq("post_rst_data", 32'(rom_data), 'hC7);
    check_eq("post_rst_valid", 32'(rom_valid), 1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
